buzz_arbiter: RTL and testbench

//  Two-player buzz-in arbiter for the factorization quiz. After a question is loaded it

---
 rtl/buzz_arbiter.sv | 172 +++++++++++++++++
 tb/tb_buzz_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/buzz_arbiter.sv
// Two-player buzz-in arbiter: grants the answer path, runs the answer time limit,
// applies HP damage from checker verdicts and declares the game winner.
module buzz_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned HP_INIT     = 3,
  parameter int unsigned HP_W        = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [1:0]      BUZZ,
  input  logic [1:0]      SUBMIT,
  input  logic            RESULT_VALID,
  input  logic            RESULT_OK,
  output logic [1:0]      GRANT,
  output logic            CHECK_REQ,
  output logic            TIMEOUT,
  output logic [1:0]      LOCKOUT,
  output logic [HP_W-1:0] HP0,
  output logic [HP_W-1:0] HP1,
  output logic [2:0]      STATE,
  output logic [1:0]      WINNER
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPEN     = 3'd1,
    S_ANSWER   = 3'd2,
    S_CHECK    = 3'd3,
    S_DONE     = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            check_req_q, check_req_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      lockout_q, lockout_d;
  logic [HP_W-1:0] hp_q [2];
  logic [HP_W-1:0] hp_d [2];
  logic [1:0]      winner_q, winner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            prio_q, prio_d;

  logic            owner;
  logic            pick;
  logic [1:0]      valid_buzz;
  logic            apply_wrong, apply_correct;

  function automatic logic [HP_W-1:0] sat_dec(input logic [HP_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign owner      = grant_q[1];
  assign valid_buzz = BUZZ & ~lockout_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    check_req_d   = 1'b0;
    timeout_d     = 1'b0;
    lockout_d     = lockout_q;
    hp_d[0]       = hp_q[0];
    hp_d[1]       = hp_q[1];
    winner_d      = winner_q;
    timer_d       = timer_q;
    prio_d        = prio_q;
    pick          = 1'b0;
    apply_wrong   = 1'b0;
    apply_correct = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_OPEN;
          lockout_d = '0;
        end
      end
      S_OPEN: begin
        if (valid_buzz != 2'b00) begin
          pick      = (valid_buzz == 2'b11) ? prio_q : valid_buzz[1];
          grant_d   = pick ? 2'b10 : 2'b01;
          prio_d    = ~pick;
          timer_d   = TW'(TIMEOUT_CYC - 1);
          state_d   = S_ANSWER;
        end
      end
      S_ANSWER: begin
        if (SUBMIT[owner]) begin
          state_d     = S_CHECK;
          check_req_d = 1'b1;
        end else if (timer_q == '0) begin
          timeout_d   = 1'b1;
          apply_wrong = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (RESULT_VALID) begin
          apply_correct = RESULT_OK;
          apply_wrong   = ~RESULT_OK;
        end
      end
      S_DONE:     state_d = S_IDLE;
      S_GAMEOVER: state_d = S_GAMEOVER;
      default:    state_d = S_IDLE;
    endcase

    // Verdict handling shared by a checker "wrong" and an answer timeout.
    if (apply_correct) begin
      hp_d[~owner] = sat_dec(hp_q[~owner]);
      grant_d      = '0;
      if (hp_d[~owner] == '0) begin
        state_d  = S_GAMEOVER;
        winner_d = grant_q;
      end else begin
        state_d = S_DONE;
      end
    end else if (apply_wrong) begin
      hp_d[owner]      = sat_dec(hp_q[owner]);
      lockout_d[owner] = 1'b1;
      grant_d          = '0;
      if (hp_d[owner] == '0) begin
        state_d  = S_GAMEOVER;
        winner_d = ~grant_q;
      end else if (lockout_q[~owner]) begin
        state_d = S_DONE;
      end else begin
        state_d = S_OPEN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      check_req_q <= 1'b0;
      timeout_q   <= 1'b0;
      lockout_q   <= '0;
      hp_q[0]     <= HP_W'(HP_INIT);
      hp_q[1]     <= HP_W'(HP_INIT);
      winner_q    <= '0;
      timer_q     <= '0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      check_req_q <= check_req_d;
      timeout_q   <= timeout_d;
      lockout_q   <= lockout_d;
      hp_q[0]     <= hp_d[0];
      hp_q[1]     <= hp_d[1];
      winner_q    <= winner_d;
      timer_q     <= timer_d;
      prio_q      <= prio_d;
    end
  end

  assign GRANT     = grant_q;
  assign CHECK_REQ = check_req_q;
  assign TIMEOUT   = timeout_q;
  assign LOCKOUT   = lockout_q;
  assign HP0       = hp_q[0];
  assign HP1       = hp_q[1];
  assign STATE     = state_q;
  assign WINNER    = winner_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter: expected output snapshots queued per step,
// compared one cycle later.
module tb_buzz_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic [1:0] BUZZ = '0;
  logic [1:0] SUBMIT = '0;
  logic       RESULT_VALID = 1'b0;
  logic       RESULT_OK = 1'b0;
  logic [1:0] GRANT;
  logic       CHECK_REQ;
  logic       TIMEOUT;
  logic [1:0] LOCKOUT;
  logic [1:0] HP0, HP1;
  logic [2:0] STATE;
  logic [1:0] WINNER;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef logic [14:0] vec_t;
  vec_t  exp_q [$];
  string tag_q [$];

  buzz_arbiter #(.TIMEOUT_CYC(4), .HP_INIT(3), .HP_W(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUZZ(BUZZ), .SUBMIT(SUBMIT),
    .RESULT_VALID(RESULT_VALID), .RESULT_OK(RESULT_OK), .GRANT(GRANT),
    .CHECK_REQ(CHECK_REQ), .TIMEOUT(TIMEOUT), .LOCKOUT(LOCKOUT),
    .HP0(HP0), .HP1(HP1), .STATE(STATE), .WINNER(WINNER)
  );

  always #5 CLK = ~CLK;

  // Snapshot layout: grant, check_req, timeout, lockout, hp0, hp1, state, winner.
  function automatic vec_t E(input logic [1:0] g, input logic cr, input logic to,
                             input logic [1:0] lk, input logic [1:0] h0,
                             input logic [1:0] h1, input logic [2:0] st,
                             input logic [1:0] w);
    return {g, cr, to, lk, h0, h1, st, w};
  endfunction

  task automatic go(input string tag, input logic rst, input logic start,
                    input logic [1:0] buzz, input logic [1:0] submit,
                    input logic rv, input logic rok, input vec_t e);
    vec_t  obs, want;
    string t;
    RST = rst; START = start; BUZZ = buzz; SUBMIT = submit;
    RESULT_VALID = rv; RESULT_OK = rok;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    obs  = {GRANT, CHECK_REQ, TIMEOUT, LOCKOUT, HP0, HP1, STATE, WINNER};
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s observed=%b expected=%b", t, obs, want);
  endtask

  initial begin
    // 1: single buzz, correct answer
    go("reset",        1, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("rv_in_idle",   0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("start",        0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,1,2'b00));
    go("grant_p0",     0, 0, 2'b01, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,2,2'b00));
    go("check_req",    0, 1, 2'b00, 2'b01, 0, 0, E(2'b01,1,0,2'b00,3,3,3,2'b00));
    go("check_wait",   0, 0, 2'b00, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,3,2'b00));
    go("correct_p0",   0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b00,3,2,4,2'b00));
    go("done_idle",    0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,2,0,2'b00));

    // 2: simultaneous buzz alternates priority
    go("reset2",       1, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("start2a",      0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,1,2'b00));
    go("tie_grant01",  0, 0, 2'b11, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,2,2'b00));
    go("submit2a",     0, 0, 2'b00, 2'b01, 0, 0, E(2'b01,1,0,2'b00,3,3,3,2'b00));
    go("correct2a",    0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b00,3,2,4,2'b00));
    go("idle2a",       0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,2,0,2'b00));
    go("start2b",      0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,2,1,2'b00));
    go("tie_grant10",  0, 0, 2'b11, 2'b00, 0, 0, E(2'b10,0,0,2'b00,3,2,2,2'b00));
    go("submit2b",     0, 0, 2'b00, 2'b10, 0, 0, E(2'b10,1,0,2'b00,3,2,3,2'b00));
    go("correct2b",    0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b00,2,2,4,2'b00));
    go("idle2b",       0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,2,2,0,2'b00));

    // 3/4: timeout, lockout, submit on last cycle, both wrong
    go("reset3",       1, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("start3",       0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,1,2'b00));
    go("grant3",       0, 0, 2'b01, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,2,2'b00));
    for (int i = 0; i < 3; i++)
      go("ans_wait",   0, 0, 2'b00, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,2,2'b00));
    go("timeout",      0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,1,2'b01,2,3,1,2'b00));
    go("locked_buzz",  0, 0, 2'b01, 2'b00, 0, 0, E(2'b00,0,0,2'b01,2,3,1,2'b00));
    go("grant_p1",     0, 0, 2'b10, 2'b00, 0, 0, E(2'b10,0,0,2'b01,2,3,2,2'b00));
    go("other_ignored",0, 0, 2'b01, 2'b01, 0, 0, E(2'b10,0,0,2'b01,2,3,2,2'b00));
    go("ans_wait2",    0, 0, 2'b00, 2'b00, 0, 0, E(2'b10,0,0,2'b01,2,3,2,2'b00));
    go("ans_wait3",    0, 0, 2'b00, 2'b00, 0, 0, E(2'b10,0,0,2'b01,2,3,2,2'b00));
    go("submit_at_0",  0, 0, 2'b00, 2'b10, 0, 0, E(2'b10,1,0,2'b01,2,3,3,2'b00));
    go("both_wrong",   0, 0, 2'b00, 2'b00, 1, 0, E(2'b00,0,0,2'b11,2,2,4,2'b00));
    go("lock_kept",    0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b11,2,2,0,2'b00));

    // 5: drive P1 to zero HP
    go("reset5",       1, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("start5a",      0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,1,2'b00));
    go("grant5a",      0, 0, 2'b10, 2'b00, 0, 0, E(2'b10,0,0,2'b00,3,3,2,2'b00));
    go("submit5a",     0, 0, 2'b00, 2'b10, 0, 0, E(2'b10,1,0,2'b00,3,3,3,2'b00));
    go("p1_wrong_a",   0, 0, 2'b00, 2'b00, 1, 0, E(2'b00,0,0,2'b10,3,2,1,2'b00));
    go("grant5b",      0, 0, 2'b11, 2'b00, 0, 0, E(2'b01,0,0,2'b10,3,2,2,2'b00));
    go("submit5b",     0, 0, 2'b00, 2'b01, 0, 0, E(2'b01,1,0,2'b10,3,2,3,2'b00));
    go("p0_right",     0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b10,3,1,4,2'b00));
    go("idle5",        0, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b10,3,1,0,2'b00));
    go("start5c",      0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,1,1,2'b00));
    go("grant5c",      0, 0, 2'b10, 2'b00, 0, 0, E(2'b10,0,0,2'b00,3,1,2,2'b00));
    go("submit5c",     0, 0, 2'b00, 2'b10, 0, 0, E(2'b10,1,0,2'b00,3,1,3,2'b00));
    go("gameover",     0, 0, 2'b00, 2'b00, 1, 0, E(2'b00,0,0,2'b10,3,0,5,2'b01));
    go("go_sticky",    0, 1, 2'b11, 2'b11, 1, 1, E(2'b00,0,0,2'b10,3,0,5,2'b01));
    go("go_reset",     1, 0, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));

    // 6: reset beats a same-cycle verdict in CHECK
    go("start6",       0, 1, 2'b00, 2'b00, 0, 0, E(2'b00,0,0,2'b00,3,3,1,2'b00));
    go("grant6",       0, 0, 2'b01, 2'b00, 0, 0, E(2'b01,0,0,2'b00,3,3,2,2'b00));
    go("submit6",      0, 0, 2'b00, 2'b01, 0, 0, E(2'b01,1,0,2'b00,3,3,3,2'b00));
    go("rst_in_check", 1, 0, 2'b00, 2'b00, 1, 0, E(2'b00,0,0,2'b00,3,3,0,2'b00));
    go("post_rst",     0, 0, 2'b00, 2'b00, 1, 1, E(2'b00,0,0,2'b00,3,3,0,2'b00));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
